// File: rtl/downcounter.sv
// downcounter: loadable N-bit down counter / interval timer.
//
// A load captures a start value (also kept as the reload value) and, when
// non-zero, starts the count. Each enabled cycle in RUN decrements q. On the
// 1 -> 0 step a one-cycle tc pulse is produced. In auto-reload mode q goes
// back to the reload value and the counter stays in RUN. In one-shot mode q
// ends at 0 and the counter parks in DONE until the next load.
//
// Ports
//   clk        in   1  system clock, posedge
//   rst_n      in   1  asynchronous active-low reset
//   load       in   1  load request (highest priority)
//   load_val   in   N  start value captured on load
//   en         in   1  count enable, one decrement per enabled cycle in RUN
//   reload_en  in   1  1: auto-reload at terminal count, 0: one-shot
//   q          out  N  current count (registered)
//   busy       out  1  state is RUN (registered)
//   tc         out  1  terminal-count pulse, one cycle wide (registered)
//   done       out  1  state is DONE (registered)
module downcounter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  input  logic         reload_en,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         tc,
  output logic         done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [N-1:0] ONE = N'(1);

  state_e       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] reload_q, reload_d;
  logic         tc_q, tc_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // Next-state: load > en > hold. tc defaults low so it is a single-cycle
  // pulse unless the terminal condition repeats (reload value of 1).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      cnt_d    = load_val;
      reload_d = load_val;
      state_d  = (load_val != '0) ? ST_RUN : ST_IDLE;
    end else if (state_q == ST_RUN && en) begin
      if (cnt_q == ONE) begin
        tc_d = 1'b1;
        if (reload_en) begin
          cnt_d = reload_q;
        end else begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end

    // Status flags are registered from the next state so they line up with q.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign q    = cnt_q;
  assign busy = busy_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule
